// File: rtl/fp32_alu_s_m.sv
// fp32_alu_s_m: byte-serial IEEE-754 binary32 add/sub with flush-to-zero and RNE rounding
module fp32_alu_s_m (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [63:0] ab_q, ab_d;
  logic op_q, op_d;
  logic [31:0] r_q, r_d;
  logic ovf_q, ovf_d, inv_q, inv_d;
  logic wr, rd, busy, unused_ok;
  logic [31:0] a, b, x, y, res;
  logic [30:0] ka, kb;
  logic a_nan, b_nan, a_inf, b_inf, swap, ovf, inv;
  logic [7:0] d;
  logic [26:0] xw, yw, y_al, norm;
  logic [27:0] sum;
  logic [4:0] lz;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic signed [9:0] e, e_r;
  assign wr = uio_in[0];
  assign rd = uio_in[2];
  assign unused_ok = ^uio_in[7:3];
  always_comb begin
    a = ab_q[31:0];
    b = {ab_q[63] ^ op_q, ab_q[62:32]};
    a_nan = &a[30:23] && |a[22:0];
    b_nan = &b[30:23] && |b[22:0];
    a_inf = &a[30:23] && ~|a[22:0];
    b_inf = &b[30:23] && ~|b[22:0];
    ka = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
    kb = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
    swap = kb > ka;
    x = swap ? {b[31], kb} : {a[31], ka};
    y = swap ? {a[31], ka} : {b[31], kb};
    xw = {|x[30:23], x[22:0], 3'b0};
    yw = {|y[30:23], y[22:0], 3'b0};
    d = x[30:23] - y[30:23];
    // bits shifted past the round position collapse into the sticky bit
    y_al = (yw >> d) | {26'd0, |(yw & ~({27{1'b1}} << d))};
    sum = (x[31] == y[31]) ? {1'b0, xw} + {1'b0, y_al} : {1'b0, xw} - {1'b0, y_al};
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    norm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << lz;
    e = sum[27] ? {2'b0, x[30:23]} + 10'sd1 : {2'b0, x[30:23]} - {5'b0, lz};
    rnd = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
    e_r = e + {9'd0, rnd[24]};
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    ovf = 1'b0;
    inv = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) begin
      res = 32'h7FC00000;
      inv = 1'b1;
    end else if (a_inf) res = {a[31], 8'hFF, 23'd0};
    else if (b_inf) res = {b[31], 8'hFF, 23'd0};
    else if (sum == 28'd0) res = {x[31] & y[31], 31'd0};
    else if (e_r <= 0) res = {x[31], 31'd0};
    else if (e_r >= 255) begin
      res = {x[31], 8'hFF, 23'd0};
      ovf = 1'b1;
    end else res = {x[31], e_r[7:0], frac};
  end
  always_ff @(posedge clk) state_q <= rst_n ? LOAD : state_d;
  always_comb
    state_d = !ena ? state_q :
              (state_q == LOAD && wr && cnt_q == 3'd7) ? CALC :
              (state_q == CALC) ? OUT :
              (state_q == OUT && rd && cnt_q == 3'd3) ? LOAD : state_q;
  always_comb begin
    cnt_d = cnt_q;
    ab_d = ab_q;
    op_d = op_q;
    r_d = r_q;
    ovf_d = ovf_q;
    inv_d = inv_q;
    if (ena && state_q == LOAD && wr) begin
      ab_d[{cnt_q, 3'b0} +: 8] = ui_in;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) op_d = uio_in[1];
    end
    if (ena && state_q == CALC) begin
      r_d = res;
      ovf_d = ovf;
      inv_d = inv;
    end
    if (ena && state_q == OUT && rd) cnt_d = (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= 3'd0;
      ab_q <= 64'd0;
      op_q <= 1'b0;
      r_q <= 32'd0;
      ovf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ab_q <= ab_d;
      op_q <= op_d;
      r_q <= r_d;
      ovf_q <= ovf_d;
      inv_q <= inv_d;
    end
  end
  always_comb begin
    busy = (state_q == LOAD && cnt_q != 3'd0) || state_q == CALC;
    uo_out = (state_q == OUT) ? r_q[{cnt_q[1:0], 3'b0} +: 8] : 8'd0;
    uio_out = {busy, inv_q, ovf_q, state_q == OUT, 4'b0};
    uio_oe = 8'hF0;
  end
endmodule

// File: tb/tb_fp32_alu_s_m.sv
// tb_fp32_alu_s_m: directed byte-serial vectors for the fp32 add/sub wrapper
module tb_fp32_alu_s_m;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] a, b;
    logic op;
    logic [31:0] r;
    logic ovf, inv;
  } vec_t;
  vec_t v[15];

  fp32_alu_s_m dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [63:0] ab;
    ab = {b, a};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_after_byte1", {30'd0, uio_out[7], uio_out[4]}, 32'h2);
      ui_in = ab[i*8 +: 8];
      uio_in = {5'd0, 1'b1, op, 1'b1};
    end
    @(negedge clk);
    uio_in = 8'h00;
    chk("calc_busy_done", {30'd0, uio_out[7], uio_out[4]}, 32'h2);
    @(negedge clk);
    chk("out_busy_done", {30'd0, uio_out[7], uio_out[4]}, 32'h1);
  endtask

  task automatic read(input string tag, input logic [31:0] r, input logic ovf, input logic inv);
    logic [31:0] rr;
    rr = r;
    chk({tag, "_flags"}, {30'd0, uio_out[6:5]}, {30'd0, inv, ovf});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, uo_out}, {24'd0, rr[k*8 +: 8]});
      uio_in = 8'h05;
      @(negedge clk);
      uio_in = 8'h00;
    end
    chk({tag, "_uio_after"}, {24'd0, uio_out}, {24'd0, 1'b0, inv, ovf, 5'd0});
    chk({tag, "_uo_after"}, {24'd0, uo_out}, 32'd0);
    chk({tag, "_oe"}, {24'd0, uio_oe}, 32'hF0);
  endtask

  initial begin
    v[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
    v[1]  = '{32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000, 1'b0, 1'b0};
    v[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    v[3]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    v[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    v[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1};
    v[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
    v[7]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    v[8]  = '{32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 1'b0, 1'b0};
    v[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0};
    v[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    v[11] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0};
    v[12] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    v[13] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0};
    v[14] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    rst_n = 1'b1;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    chk("reset_uio_out", {24'd0, uio_out}, 32'd0);
    chk("reset_uo_out", {24'd0, uo_out}, 32'd0);
    chk("reset_oe", {24'd0, uio_oe}, 32'hF0);

    load(v[0].a, v[0].b, v[0].op);
    ena = 1'b0;
    uio_in = 8'h04;
    repeat (2) @(negedge clk);
    chk("ena0_hold_byte", {24'd0, uo_out}, 32'h00);
    chk("ena0_hold_done", {31'd0, uio_out[4]}, 32'd1);
    ena = 1'b1;
    uio_in = 8'h04;
    @(negedge clk);
    uio_in = 8'h00;
    chk("ena1_advance", {24'd0, uo_out}, 32'h00);
    for (int k = 0; k < 3; k++) begin
      uio_in = 8'h04;
      @(negedge clk);
      uio_in = 8'h00;
    end
    chk("ena_seq_back_to_load", {24'd0, uio_out}, 32'd0);

    for (int n = 0; n < 15; n++) begin
      load(v[n].a, v[n].b, v[n].op);
      read($sformatf("vec%0d", n), v[n].r, v[n].ovf, v[n].inv);
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ui_in = 8'hA5;
      uio_in = 8'h01;
    end
    @(negedge clk);
    uio_in = 8'h00;
    chk("mid_load_busy", {31'd0, uio_out[7]}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("mid_reset_uio_out", {24'd0, uio_out}, 32'd0);
    chk("mid_reset_uo_out", {24'd0, uo_out}, 32'd0);
    load(v[0].a, v[0].b, v[0].op);
    read("after_reset", v[0].r, v[0].ovf, v[0].inv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp32_alu_s_m.md
Name: fp32_alu_s_m

Overview:
- Tiny-Tapeout-style wrapper around a single-precision (IEEE 754 binary32) adder/subtractor.
- Operands are loaded one byte per cycle over the 8-bit dedicated input bus. The 32-bit result is read back one byte per cycle on the dedicated output bus.
- Status flags and handshake strobes use the bidirectional IO bank.
- Top-level user project; the only block in the design.

Parameters:
- None. Fixed at 32-bit operands and 8-bit bus.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-high (asserted when 1; name kept per codebase).
- ena  input  1  design enable. When 0, all state holds and strobes are ignored.
- ui_in  input  8  operand data byte.
- uio_in  input  8  bit0 = wr strobe; bit1 = op (0 add, 1 sub); bit2 = rd strobe; bits7:3 ignored.
- uo_out  output  8  current result byte.
- uio_out  output  8  bit4 = done; bit5 = overflow; bit6 = invalid; bit7 = busy; bits3:0 = 0.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- Reset (rst_n=1 at clock edge):
  - state = LOAD, byte counter = 0, operand and result registers = 0, flags = 0.
  - uo_out = 0, uio_out = 0.
- FSM: LOAD -> CALC -> OUT -> LOAD.
- LOAD:
  - Each cycle with ena=1 and wr=1 captures ui_in into the next operand byte.
  - Byte order: A[7:0], A[15:8], A[23:16], A[31:24], then B[7:0] … B[31:24] (little-endian, A first).
  - op is sampled on the 8th byte; the state then goes to CALC.
  - rd is ignored in LOAD.
  - busy = 1 from the 1st captured byte until the result is computed.
- CALC:
  - Exactly one cycle. Computes R = A + B (op=0) or A − B (op=1; flip the sign of B).
  - Registers R and the flags, then enters OUT.
  - busy = 0, done = 1 from the following cycle.
  - Latency: the 8th wr edge is edge N; done and the R[7:0] byte are visible after edge N+1.
- OUT:
  - uo_out = R byte at the read index, starting at R[7:0].
  - Each cycle with ena=1 and rd=1 advances the index.
  - After the 4th rd (R[31:24] consumed): done clears, flags hold until the next CALC, state returns to LOAD with counter 0.
  - wr is ignored in OUT.
  - In LOAD, uo_out = 0.
- Arithmetic:
  - Sign-magnitude align: swap so that |X| ≥ |Y|, then right-shift the smaller significand (hidden bit restored) by the exponent difference, keeping guard, round and sticky bits.
  - Add or subtract the significands, then normalise with a leading-zero count and left shift, or a 1-bit right shift on carry-out.
  - Rounding: round-to-nearest, ties-to-even. A rounding carry renormalises and increments the exponent.
- Denormals: flush-to-zero. Any input with exp = 0 is treated as ±0. A result whose exponent underflows (≤ 0) becomes a signed zero with no flag.
- Special cases:
  - Any NaN input -> 0x7FC00000, invalid = 1.
  - +inf + −inf (after op applied) -> 0x7FC00000, invalid = 1.
  - inf ± finite -> that inf.
  - Finite overflow (exp ≥ 255 after rounding) -> ±inf (0x7F800000 / 0xFF800000), overflow = 1.
  - Exact cancellation x + (−x) -> +0.
  - (−0) + (−0) -> −0.
  - (+0) + (−0) -> +0.
- Reset mid-operation: returns to LOAD immediately; partial operands are discarded.
- Simultaneous wr and rd: only the strobe relevant to the current state acts.
- ena = 0: state, counters and outputs frozen.

Test Plan:
- Load A = 0x3F800000 (bytes 00 00 80 3F), B = 0x40000000, op = 0 -> done two edges after the 8th byte; reads give 00 00 40 40 (R = 0x40400000); flags 0.
- A = 0x3FC00000, B = 0x3F000000, op = 1 -> R = 0x3F800000.
- A = 0x3F800000, B = 0x33800000 (tie) -> R = 0x3F800000. With B = 0x33800001 -> R = 0x3F800001.
- A = B = 0x7F7FFFFF, op = 0 -> R = 0x7F800000, overflow = 1.
- A = 0x7F800000, B = 0x7F800000, op = 1 -> R = 0x7FC00000, invalid = 1.
- Assert rst_n after 5 bytes loaded -> counter 0, busy = 0; a full fresh 8-byte load then gives the correct result. Also check uio_oe = 0xF0 at all times.
